video_pattern_gen: RTL and testbench

Parametrised video timing and test-pattern source that drives the Pocket scaler video bus (rgb, de, skip, vs, hs) from a single pixel clock. It generalises our fixed dummy video source. Active window, sync positions and frame size are parameters. Four runtime-selectable patterns are provided, switched only on frame boundaries. Also provides frame gating, a frame counter and pixel coordinates. Used for bring-up and scaler verification in place of a real core.

---
 rtl/video_pattern_gen.sv | 251 +++++++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern source for the Pocket scaler bus.
// Runs whole frames; pattern and solid colour are switched only at frame wrap.
module video_pattern_gen #(
  parameter int H_TOTAL        = 740,
  parameter int V_TOTAL        = 500,
  parameter int H_SYNC_POS     = 50,
  parameter int V_SYNC_POS     = 50,
  parameter int H_ACTIVE_START = 100,
  parameter int H_ACTIVE       = 400,
  parameter int V_ACTIVE_START = 100,
  parameter int V_ACTIVE       = 360,
  parameter int COUNT_W        = 12,
  parameter int CHECKER_LOG2   = 4
) (
  input  logic               rgb_clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [1:0]         mode_req,
  input  logic [23:0]        solid_rgb,
  output logic [1:0]         mode_active,
  output logic [23:0]        rgb,
  output logic               de,
  output logic               skip,
  output logic               vs,
  output logic               hs,
  output logic [COUNT_W-1:0] x,
  output logic [COUNT_W-1:0] y,
  output logic [15:0]        frame_count
);

  localparam int HA_END = H_ACTIVE_START + H_ACTIVE;
  localparam int VA_END = V_ACTIVE_START + V_ACTIVE;
  localparam int CW1    = COUNT_W + 1;

  localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] HS_POS = COUNT_W'(H_SYNC_POS);
  localparam logic [COUNT_W-1:0] VS_POS = COUNT_W'(V_SYNC_POS);
  localparam logic [COUNT_W-1:0] HA_S   = COUNT_W'(H_ACTIVE_START);
  localparam logic [COUNT_W-1:0] VA_S   = COUNT_W'(V_ACTIVE_START);
  localparam logic [CW1-1:0]     HA_E   = CW1'(HA_END);
  localparam logic [CW1-1:0]     VA_E   = CW1'(VA_END);
  localparam logic [COUNT_W-1:0] BAR_W  = COUNT_W'(H_ACTIVE / 8);
  localparam logic [COUNT_W-1:0] BAR_MX = COUNT_W'(7);

  // Parameter sanity checks at elaboration
  if (HA_END > H_TOTAL) begin : g_bad_h_window
    $fatal(1, "active window exceeds H_TOTAL");
  end
  if (VA_END > V_TOTAL) begin : g_bad_v_window
    $fatal(1, "active window exceeds V_TOTAL");
  end
  if (H_SYNC_POS >= H_TOTAL) begin : g_bad_hs
    $fatal(1, "H_SYNC_POS must be below H_TOTAL");
  end
  if (V_SYNC_POS >= V_TOTAL) begin : g_bad_vs
    $fatal(1, "V_SYNC_POS must be below V_TOTAL");
  end
  if (H_TOTAL > (1 << COUNT_W)) begin : g_bad_hw
    $fatal(1, "H_TOTAL does not fit COUNT_W");
  end
  if (V_TOTAL > (1 << COUNT_W)) begin : g_bad_vw
    $fatal(1, "V_TOTAL does not fit COUNT_W");
  end
  if (H_ACTIVE < 8) begin : g_bad_ha
    $fatal(1, "H_ACTIVE must be at least 8");
  end
  if (CHECKER_LOG2 >= COUNT_W) begin : g_bad_chk
    $fatal(1, "CHECKER_LOG2 must be below COUNT_W");
  end

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [COUNT_W-1:0] hcount_q, hcount_d;
  logic [COUNT_W-1:0] vcount_q, vcount_d;
  logic [1:0]         mode_q, mode_d;
  logic [23:0]        solid_q, solid_d;
  logic [15:0]        frame_q, frame_d;
  logic [23:0]        grad_q, grad_d;

  logic [23:0]        rgb_q, rgb_d;
  logic               de_q, de_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic [COUNT_W-1:0] x_q, x_d;
  logic [COUNT_W-1:0] y_q, y_d;

  logic               run;
  logic               frame_wrap;
  logic               h_act;
  logic               v_act;
  logic               act;
  logic [COUNT_W-1:0] xo;
  logic [COUNT_W-1:0] yo;
  logic [COUNT_W-1:0] bar_idx;
  logic [2:0]         bar_sel;
  logic [23:0]        grad_cur;

  function automatic logic [23:0] grad_step(input logic [23:0] c);
    logic [23:0] n;
    n = c;
    if (c[23:16] < 8'd254) begin
      n[23:16] = c[23:16] + 8'd2;
    end else if (c[15:8] < 8'd254) begin
      n[15:8] = c[15:8] + 8'd2;
    end else if (c[7:0] < 8'd254) begin
      n[7:0] = c[7:0] + 8'd2;
    end
    return n;
  endfunction

  function automatic logic [23:0] bar_rgb(input logic [2:0] b);
    logic [23:0] c;
    case (b)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  assign run        = (state_q == RUN);
  assign frame_wrap = run && (hcount_q == H_LAST) && (vcount_q == V_LAST);

  assign h_act = (hcount_q >= HA_S) && ({1'b0, hcount_q} < HA_E);
  assign v_act = (vcount_q >= VA_S) && ({1'b0, vcount_q} < VA_E);
  assign act   = run && h_act && v_act;
  assign xo    = hcount_q - HA_S;
  assign yo    = vcount_q - VA_S;

  assign bar_idx  = xo / BAR_W;
  assign bar_sel  = (bar_idx > BAR_MX) ? 3'd7 : bar_idx[2:0];
  assign grad_cur = (hcount_q == HA_S) ? 24'h0 : grad_q;

  // Sequencer: idle/run state, raster counters, frame-boundary latching
  always_comb begin
    state_d  = state_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    mode_d   = mode_q;
    solid_d  = solid_q;
    frame_d  = frame_q;
    unique case (state_q)
      IDLE: begin
        hcount_d = '0;
        vcount_d = '0;
        if (enable) begin
          state_d = RUN;
          mode_d  = mode_req;
          solid_d = solid_rgb;
        end
      end
      RUN: begin
        if (hcount_q == H_LAST) begin
          hcount_d = '0;
          if (vcount_q == V_LAST) begin
            vcount_d = '0;
          end else begin
            vcount_d = vcount_q + 1'b1;
          end
        end else begin
          hcount_d = hcount_q + 1'b1;
        end
        if (frame_wrap) begin
          frame_d = frame_q + 16'd1;
          mode_d  = mode_req;
          solid_d = solid_rgb;
          if (!enable) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Video outputs for the current counter position, one clock later
  always_comb begin
    rgb_d  = 24'h0;
    grad_d = grad_q;
    de_d   = act;
    hs_d   = run && (hcount_q == HS_POS);
    vs_d   = run && (vcount_q == VS_POS) && (hcount_q == '0);
    x_d    = act ? xo : '0;
    y_d    = act ? yo : '0;
    if (act) begin
      grad_d = grad_step(grad_cur);
      unique case (mode_q)
        2'd0: rgb_d = grad_cur;
        2'd1: rgb_d = bar_rgb(bar_sel);
        2'd2: rgb_d = (xo[CHECKER_LOG2] ^ yo[CHECKER_LOG2]) ?
                      24'hFFFFFF : 24'h000000;
        2'd3: rgb_d = solid_q;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge rgb_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      hcount_q <= '0;
      vcount_q <= '0;
      mode_q   <= 2'd0;
      solid_q  <= 24'h0;
      frame_q  <= 16'd0;
      grad_q   <= 24'h0;
      rgb_q    <= 24'h0;
      de_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      mode_q   <= mode_d;
      solid_q  <= solid_d;
      frame_q  <= frame_d;
      grad_q   <= grad_d;
      rgb_q    <= rgb_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign mode_active = mode_q;
  assign rgb         = rgb_q;
  assign de          = de_q;
  assign skip        = 1'b0;
  assign vs          = vs_q;
  assign hs          = hs_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen.
// Instance a: small raster; instance b: default line, short frame.
module tb_video_pattern_gen;

  logic        clk;
  logic        rst_n;
  logic        en_a, en_b;
  logic [1:0]  mode_a, mode_b;
  logic [23:0] solid_a, solid_b;

  logic [1:0]  ma_a, ma_b;
  logic [23:0] rgb_a, rgb_b;
  logic        de_a, de_b, skip_a, skip_b;
  logic        vs_a, vs_b, hs_a, hs_b;
  logic [11:0] x_a, x_b, y_a, y_b;
  logic [15:0] fc_a, fc_b;

  int n_chk = 0;
  int n_fail = 0;

  video_pattern_gen #(
    .H_TOTAL(20), .V_TOTAL(10),
    .H_SYNC_POS(2), .V_SYNC_POS(1),
    .H_ACTIVE_START(4), .H_ACTIVE(8),
    .V_ACTIVE_START(2), .V_ACTIVE(4),
    .COUNT_W(12), .CHECKER_LOG2(4)
  ) u_a (
    .rgb_clock(clk), .reset_n(rst_n), .enable(en_a),
    .mode_req(mode_a), .solid_rgb(solid_a), .mode_active(ma_a),
    .rgb(rgb_a), .de(de_a), .skip(skip_a), .vs(vs_a), .hs(hs_a),
    .x(x_a), .y(y_a), .frame_count(fc_a)
  );

  video_pattern_gen #(
    .H_TOTAL(740), .V_TOTAL(24),
    .H_SYNC_POS(50), .V_SYNC_POS(1),
    .H_ACTIVE_START(100), .H_ACTIVE(400),
    .V_ACTIVE_START(2), .V_ACTIVE(20),
    .COUNT_W(12), .CHECKER_LOG2(4)
  ) u_b (
    .rgb_clock(clk), .reset_n(rst_n), .enable(en_b),
    .mode_req(mode_b), .solid_rgb(solid_b), .mode_active(ma_b),
    .rgb(rgb_b), .de(de_b), .skip(skip_b), .vs(vs_b), .hs(hs_b),
    .x(x_b), .y(y_b), .frame_count(fc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [23:0] bars [8];
    int n, bad, hs_cnt, vs_cnt, de_cnt, rise_cnt, max_x, max_y;
    logic prev_de;
    logic [15:0] fc;

    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0;
    mode_a = 2'd1; mode_b = 2'd0;
    solid_a = 24'h0; solid_b = 24'h0;
    repeat (3) tick();

    chk("rst_b_rgb", 32'(rgb_b), 0);
    chk("rst_b_flags", 32'({de_b, hs_b, vs_b, skip_b}), 0);
    chk("rst_b_xy", 32'({x_b, y_b}), 0);
    chk("rst_b_fc", 32'(fc_b), 0);
    chk("rst_b_mode", 32'(ma_b), 0);
    chk("rst_a_flags", 32'({de_a, hs_a, vs_a, skip_a, ma_a}), 0);
    chk("rst_a_rgb", 32'(rgb_a), 0);

    rst_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      tick();
      if (rgb_b != 0 || de_b || hs_b || vs_b || skip_b ||
          x_b != 0 || y_b != 0 || ma_b != 0 || fc_b != 0) bad++;
    end
    chk("idle_outputs", bad, 0);
    chk("idle_fc", 32'(fc_b), 0);

    // b: gradient, default line timing
    en_b = 1'b1;
    tick();
    n = 0;
    while (!hs_b && n < 2000) begin tick(); n++; end
    chk("b_first_hs", n, 51);
    tick();
    chk("b_hs_width", 32'(hs_b), 0);

    n = 0;
    while (!de_b && n < 20000) begin tick(); n++; end
    chk("b_de_found", 32'(de_b), 1);
    chk("b_p0_xy", 32'({x_b, y_b}), 0);
    chk("grad_p0", 32'(rgb_b), 'h000000);
    tick();
    chk("grad_p1_x", 32'(x_b), 1);
    chk("grad_p1", 32'(rgb_b), 'h020000);
    repeat (126) tick();
    chk("grad_p127_x", 32'(x_b), 127);
    chk("grad_p127", 32'(rgb_b), 'hFE0000);
    tick();
    chk("grad_p128", 32'(rgb_b), 'hFE0200);
    repeat (126) tick();
    chk("grad_p254", 32'(rgb_b), 'hFEFE00);
    tick();
    chk("grad_p255", 32'(rgb_b), 'hFEFE02);
    repeat (144) tick();
    chk("grad_p399_x", 32'(x_b), 399);
    chk("grad_p399", 32'(rgb_b), 'hFEFEFE);
    tick();
    chk("b_line_end_de", 32'(de_b), 0);
    chk("b_line_end_rgb", 32'(rgb_b), 0);
    chk("b_line_end_x", 32'(x_b), 0);

    n = 0;
    while (!de_b && n < 2000) begin tick(); n++; end
    chk("b_line1_y", 32'(y_b), 1);
    chk("grad_line1_p0", 32'(rgb_b), 'h000000);
    tick();
    chk("grad_line1_p1", 32'(rgb_b), 'h020000);

    // b: checker, requested mid-frame
    mode_b = 2'd2;
    tick();
    chk("b_mode_hold", 32'(ma_b), 0);
    chk("b_grad_hold", 32'(rgb_b), 'h040000);
    n = 0;
    while (fc_b != 16'd1 && n < 20000) begin tick(); n++; end
    chk("b_frame1", 32'(fc_b), 1);
    chk("b_mode_chk", 32'(ma_b), 2);
    n = 0;
    while (!de_b && n < 2000) begin tick(); n++; end
    chk("b_chk_start", 32'({x_b, y_b}), 0);
    repeat (15) tick();
    chk("chk_15_0_x", 32'(x_b), 15);
    chk("chk_15_0", 32'(rgb_b), 'h000000);
    tick();
    chk("chk_16_0", 32'(rgb_b), 'hFFFFFF);
    n = 0;
    while (!(de_b && x_b == 12'd16 && y_b == 12'd16) && n < 20000) begin
      tick(); n++;
    end
    chk("chk_16_16_found", 32'(de_b), 1);
    chk("chk_16_16", 32'(rgb_b), 'h000000);

    // a: colour bars, small raster
    en_a = 1'b1;
    tick();
    n = 0;
    while (!hs_a && n < 100) begin tick(); n++; end
    chk("a_first_hs", n, 3);
    n = 0;
    do begin tick(); n++; end while (!hs_a && n < 100);
    chk("a_hs_period", n, 20);
    n = 0;
    while (!vs_a && n < 400) begin tick(); n++; end
    chk("a_vs_found", 32'(vs_a), 1);
    n = 0;
    do begin tick(); n++; end while (!vs_a && n < 400);
    chk("a_vs_period", n, 200);

    de_cnt = 0; rise_cnt = 0; max_x = 0; max_y = 0;
    hs_cnt = 0; vs_cnt = 0; prev_de = 1'b0; bad = 0;
    repeat (200) begin
      tick();
      if (de_a) begin
        de_cnt++;
        if (!prev_de) rise_cnt++;
        if (int'(x_a) > max_x) max_x = int'(x_a);
        if (int'(y_a) > max_y) max_y = int'(y_a);
      end else if (rgb_a != 0 || x_a != 0 || y_a != 0) begin
        bad++;
      end
      if (hs_a) hs_cnt++;
      if (vs_a) vs_cnt++;
      if (skip_a) bad++;
      prev_de = de_a;
    end
    chk("a_de_cycles", de_cnt, 32);
    chk("a_de_lines", rise_cnt, 4);
    chk("a_max_x", max_x, 7);
    chk("a_max_y", max_y, 3);
    chk("a_hs_per_frame", hs_cnt, 10);
    chk("a_vs_per_frame", vs_cnt, 1);
    chk("a_blank_zero", bad, 0);

    n = 0;
    while (!de_a && n < 100) begin tick(); n++; end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bar%0d_x", i), 32'(x_a), i);
      chk($sformatf("bar%0d_rgb", i), 32'(rgb_a), 32'(bars[i]));
      tick();
    end
    chk("a_bar_end_de", 32'(de_a), 0);

    // a: gradient, then solid requested mid-frame
    mode_a = 2'd0;
    fc = fc_a;
    n = 0;
    while (fc_a == fc && n < 300) begin tick(); n++; end
    chk("a_mode0", 32'(ma_a), 0);
    n = 0;
    while (!de_a && n < 300) begin tick(); n++; end
    chk("a_grad_p0", 32'(rgb_a), 0);
    fc = fc_a;
    mode_a = 2'd3;
    solid_a = 24'h123456;
    tick();
    chk("a_mode_hold", 32'(ma_a), 0);
    chk("a_grad_hold", 32'(rgb_a), 'h020000);
    n = 0;
    while (fc_a == fc && n < 300) begin tick(); n++; end
    chk("a_fc_inc", 32'(fc_a), 32'(fc + 16'd1));
    chk("a_mode3", 32'(ma_a), 3);
    n = 0;
    while (!de_a && n < 300) begin tick(); n++; end
    chk("solid_p0", 32'(rgb_a), 'h123456);
    tick();
    chk("solid_p1", 32'(rgb_a), 'h123456);

    // a: enable dropped mid-frame, frame runs to wrap
    en_a = 1'b0;
    fc = fc_a;
    n = 0; hs_cnt = 0;
    while (fc_a == fc && n < 300) begin
      tick(); n++;
      if (hs_a) hs_cnt++;
    end
    chk("drop_wrap_cycles", n, 154);
    chk("drop_hs_count", hs_cnt, 7);
    chk("drop_fc", 32'(fc_a), 32'(fc + 16'd1));
    bad = 0;
    repeat (60) begin
      tick();
      if (de_a || hs_a || vs_a || rgb_a != 0 || x_a != 0 || y_a != 0) bad++;
    end
    chk("drop_idle_zero", bad, 0);
    chk("drop_idle_fc", 32'(fc_a), 32'(fc + 16'd1));

    // a: asynchronous reset mid-line
    en_a = 1'b1;
    n = 0;
    while (!de_a && n < 400) begin tick(); n++; end
    tick();
    chk("pre_rst_de", 32'(de_a), 1);
    chk("pre_rst_rgb", 32'(rgb_a), 'h123456);
    rst_n = 1'b0;
    #1;
    chk("rst_async_de", 32'(de_a), 0);
    chk("rst_async_rgb", 32'(rgb_a), 0);
    chk("rst_async_x", 32'(x_a), 0);
    chk("rst_async_mode", 32'(ma_a), 0);
    chk("rst_async_fc", 32'(fc_a), 0);
    chk("rst_async_fc_b", 32'(fc_b), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_mode", 32'(ma_a), 3);
    n = 0;
    while (!hs_a && n < 100) begin tick(); n++; end
    chk("restart_hs", n, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
